rc5_round_ctrl: RTL

Sequencing controller and iterative round engine for the RC5-32/12 block cipher core. It accepts a 64-bit block over a valid/ready handshake and applies input whitening plus one full RC5 round per clock. It fetches subkey pairs from an external expanded-key table by round index and presents the result over an output valid/ready handshake. It sits between the block input register and the cipher output bus, and owns all round scheduling for the datapath.

---
 rtl/rc5_pkg.sv | 39 +++
 rtl/rc5_round.sv | 34 +++
 rtl/rc5_round_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/rc5_pkg.sv
// Shared types and rotate helpers for the RC5-32/12 round controller.
// RC5_CTRL_DECRYPT_EN adds the FINAL state used by the decrypt path.
package rc5_pkg;

    localparam int RC5_W      = 32;
    localparam int RC5_ROUNDS = 12;
    localparam int RC5_LGW    = $clog2(RC5_W);

    typedef logic [RC5_W-1:0]   word_t;
    typedef logic [RC5_LGW-1:0] rot_t;

`ifdef RC5_CTRL_DECRYPT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2,
        ST_FINAL = 2'd3
    } rc5_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } rc5_state_t;
`endif

    function automatic word_t rotl(input word_t x, input rot_t n);
        logic [2*RC5_W-1:0] t;
        t = {x, x} << n;
        return t[2*RC5_W-1:RC5_W];
    endfunction

    function automatic word_t rotr(input word_t x, input rot_t n);
        logic [2*RC5_W-1:0] t;
        t = {x, x} >> n;
        return t[RC5_W-1:0];
    endfunction

endpackage

// File: rtl/rc5_round.sv
// Combinational RC5 round: one encrypt round, plus the inverse round
// when RC5_CTRL_DECRYPT_EN is defined.
module rc5_round
    import rc5_pkg::*;
(
    input  word_t a_i,
    input  word_t b_i,
    input  word_t s_even_i,
    input  word_t s_odd_i,
    output word_t enc_a_o,
    output word_t enc_b_o
`ifdef RC5_CTRL_DECRYPT_EN
    ,
    output word_t dec_a_o,
    output word_t dec_b_o
`endif
);

    word_t enc_a;

    assign enc_a   = rotl(a_i ^ b_i, b_i[RC5_LGW-1:0]) + s_even_i;
    assign enc_a_o = enc_a;
    assign enc_b_o = rotl(b_i ^ enc_a, enc_a[RC5_LGW-1:0]) + s_odd_i;

`ifdef RC5_CTRL_DECRYPT_EN
    word_t dec_b;

    // B is recovered first because A's rotate amount depends on it.
    assign dec_b   = rotr(b_i - s_odd_i, a_i[RC5_LGW-1:0]) ^ a_i;
    assign dec_b_o = dec_b;
    assign dec_a_o = rotr(a_i - s_even_i, dec_b[RC5_LGW-1:0]) ^ dec_b;
`endif

endmodule

// File: rtl/rc5_round_ctrl.sv
// RC5-32/12 sequencing controller: whitening, one round per clock, result hold.
// Build option RC5_CTRL_DECRYPT_EN adds the dec input and the decrypt schedule.
//
// state | meaning
// IDLE  | ready for a block; encrypt whitening applied on accept
// ROUND | one full round per cycle, skey_idx = round counter
// FINAL | decrypt only: strip the input whitening using S[0], S[1]
// DONE  | result held on out_data until out_ready
module rc5_round_ctrl
    import rc5_pkg::*;
#(
    // W must match RC5_W; the rotate helpers are sized by the package.
    parameter int W      = RC5_W,
    parameter int ROUNDS = RC5_ROUNDS,
    parameter int IDXW   = $clog2(ROUNDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*W-1:0]    in_data,
`ifdef RC5_CTRL_DECRYPT_EN
    input  logic              dec,
`endif
    output logic [IDXW-1:0]   skey_idx,
    input  logic [W-1:0]      skey_even,
    input  logic [W-1:0]      skey_odd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*W-1:0]    out_data,
    output logic              busy
);

    rc5_state_t        state_q, state_d;
    logic [W-1:0]      a_q, a_d, b_q, b_d;
    logic [IDXW-1:0]   rnd_q, rnd_d;
    logic [W-1:0]      in_a, in_b;
    logic [W-1:0]      enc_a, enc_b;
`ifdef RC5_CTRL_DECRYPT_EN
    logic              dec_q, dec_d;
    logic [W-1:0]      dec_a, dec_b;
`endif

    assign in_a = in_data[W-1:0];
    assign in_b = in_data[2*W-1:W];

    rc5_round u_round (
        .a_i      (a_q),
        .b_i      (b_q),
        .s_even_i (skey_even),
        .s_odd_i  (skey_odd),
        .enc_a_o  (enc_a),
        .enc_b_o  (enc_b)
`ifdef RC5_CTRL_DECRYPT_EN
        ,
        .dec_a_o  (dec_a),
        .dec_b_o  (dec_b)
`endif
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        rnd_d     = rnd_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        skey_idx  = '0;
`ifdef RC5_CTRL_DECRYPT_EN
        dec_d     = dec_q;
`endif
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_ROUND;
`ifdef RC5_CTRL_DECRYPT_EN
                    dec_d = dec;
                    if (dec) begin
                        a_d   = in_a;
                        b_d   = in_b;
                        rnd_d = IDXW'(ROUNDS);
                    end else begin
                        a_d   = in_a + skey_even;
                        b_d   = in_b + skey_odd;
                        rnd_d = IDXW'(1);
                    end
`else
                    a_d   = in_a + skey_even;
                    b_d   = in_b + skey_odd;
                    rnd_d = IDXW'(1);
`endif
                end
            end
            ST_ROUND: begin
                skey_idx = rnd_q;
`ifdef RC5_CTRL_DECRYPT_EN
                if (dec_q) begin
                    a_d = dec_a;
                    b_d = dec_b;
                    if (rnd_q == IDXW'(1)) begin
                        state_d = ST_FINAL;
                        rnd_d   = '0;
                    end else begin
                        rnd_d = rnd_q - IDXW'(1);
                    end
                end else begin
                    a_d = enc_a;
                    b_d = enc_b;
                    if (rnd_q == IDXW'(ROUNDS)) begin
                        state_d = ST_DONE;
                    end else begin
                        rnd_d = rnd_q + IDXW'(1);
                    end
                end
`else
                a_d = enc_a;
                b_d = enc_b;
                if (rnd_q == IDXW'(ROUNDS)) begin
                    state_d = ST_DONE;
                end else begin
                    rnd_d = rnd_q + IDXW'(1);
                end
`endif
            end
`ifdef RC5_CTRL_DECRYPT_EN
            ST_FINAL: begin
                a_d     = a_q - skey_even;
                b_d     = b_q - skey_odd;
                state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rnd_q   <= '0;
`ifdef RC5_CTRL_DECRYPT_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rnd_q   <= rnd_d;
`ifdef RC5_CTRL_DECRYPT_EN
            dec_q   <= dec_d;
`endif
        end
    end

    assign out_data = {b_q, a_q};
    assign busy     = (state_q != ST_IDLE);

endmodule
